// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
//   Streaming wrapper around a fixed-latency, non-stallable AES-128 core.
//   Accepted blocks are registered toward the core, tracked by a one-hot tag
//   pipeline, and their ciphertext is captured into an output FIFO. A credit
//   rule (in-flight + buffered < DEPTH) gates acceptance so that every core
//   result always finds a free FIFO slot.
//
// Parameters
//   LATENCY : edges from core_state/core_key registered to core_out valid
//   DEPTH   : output FIFO entries (power of two, 2..16)
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake
//   in_state, in_key     : plaintext block and cipher key
//   core_state, core_key : registered core inputs
//   core_out             : core ciphertext
//   out_valid/out_ready  : downstream handshake
//   out_data             : FIFO head (0 when empty)
//   blk_count            : popped-block counter
//
// Configuration
//   AES_STREAM_BLKCNT_EN : when defined, blk_count counts FIFO pops
//                          (wrapping); otherwise blk_count is tied to 0.
module aes_stream_ctrl #(
  parameter int LATENCY = 21,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [31:0]  blk_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LATENCY-1:0] r_tag;
  logic               r_tag_exit;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_occ;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [127:0]       r_mem [DEPTH];
  logic [127:0]       r_core_state;
  logic [127:0]       r_core_key;

  logic               w_accept;
  logic               w_pop;
  logic               w_wr;
  logic [CW:0]        w_credit_used;

  // Credits count everything accepted but not yet popped, so the FIFO can
  // never be asked to hold more than DEPTH results.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_occ};
  assign in_ready      = (w_credit_used < (CW + 1)'(DEPTH));
  assign w_accept      = in_valid & in_ready;
  assign out_valid     = (r_occ != '0);
  assign w_pop         = out_valid & out_ready;

  // core_out turns to this block's ciphertext on the same edge that the tag
  // leaves the shift register, so the capture happens one edge later.
  assign w_wr = r_tag_exit;

  assign core_state = r_core_state;
  assign core_key   = r_core_key;
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag        <= '0;
      r_tag_exit   <= 1'b0;
      r_inflight   <= '0;
      r_occ        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_core_state <= '0;
      r_core_key   <= '0;
    end else begin
      r_tag      <= LATENCY'({r_tag, w_accept});
      r_tag_exit <= r_tag[LATENCY-1];

      if (w_accept) begin
        r_core_state <= in_state;
        r_core_key   <= in_key;
      end

      case ({w_accept, w_wr})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= core_out;
  end

`ifdef AES_STREAM_BLKCNT_EN
  logic [31:0] r_blk_count;

  always_ff @(posedge clk) begin
    if (rst)        r_blk_count <= '0;
    else if (w_pop) r_blk_count <= r_blk_count + 32'd1;
  end

  assign blk_count = r_blk_count;
`else
  assign blk_count = '0;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
module tb_aes_stream_ctrl;

  localparam int LAT   = 21;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [31:0]  blk_count;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .core_state(core_state),
    .core_key(core_key), .core_out(core_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .blk_count(blk_count)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- AES core model: LAT-edge pipeline ----------------
  logic [127:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= aes_enc(core_state, core_key);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign core_out = pipe[LAT-1];

  // ---------------- reference model of the stream ----------------
  // Every accepted block is owed back in order; it may appear no earlier
  // than LAT+2 cycles after acceptance. Credits = accepted - popped.
  logic [127:0] q  [$];
  int           qt [$];
  int           cyc = 0;
  int           pops = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           exp_rdy;
  bit           exp_vld;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    bit acc;
    bit pop;
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    pop = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (rst) begin
      q.delete(); qt.delete(); pops = 0;
    end else begin
      if (pop && q.size() > 0) begin void'(q.pop_front()); void'(qt.pop_front()); pops++; end
      if (acc) begin q.push_back(aes_enc(in_state, in_key)); qt.push_back(cyc); end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_state = rnd128(); in_key = rnd128();
    repeat (3) step();
    rst = 1'b0; in_valid = 1'b0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready actual=%b required=1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid actual=%b required=0", out_valid); end
    n_chk++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL rst_out_data actual=%h required=0", out_data); end
    n_chk++; if (blk_count !== 32'h0) begin n_fail++; $display("FAIL rst_blk_count actual=%0d required=0", blk_count); end
    n_chk++; if (core_state !== 128'h0) begin n_fail++; $display("FAIL rst_core_state actual=%h required=0", core_state); end
    n_chk++; if (core_key !== 128'h0) begin n_fail++; $display("FAIL rst_core_key actual=%h required=0", core_key); end
  endtask

  task automatic test_known_vector();
    int acc_cyc;
    int seen;
    out_ready = 1'b1; in_valid = 1'b1;
    in_key   = 128'h000102030405060708090a0b0c0d0e0f;
    in_state = 128'h00112233445566778899aabbccddeeff;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kv_in_ready actual=%b required=1", in_ready); end
    acc_cyc = cyc;
    step();
    in_valid = 1'b0;
    n_chk++; if (core_state !== 128'h00112233445566778899aabbccddeeff) begin n_fail++; $display("FAIL kv_core_state actual=%h required=00112233445566778899aabbccddeeff", core_state); end
    n_chk++; if (core_key !== 128'h000102030405060708090a0b0c0d0e0f) begin n_fail++; $display("FAIL kv_core_key actual=%h required=000102030405060708090a0b0c0d0e0f", core_key); end
    seen = -1;
    for (int c = 0; c < LAT + 6; c++) begin
      exp_vld = (q.size() > 0) && (cyc - qt[0] >= LAT + 2);
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL kv_out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, exp_vld); end
      if (out_valid === 1'b1 && seen < 0) begin
        seen = cyc;
        n_chk++; if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_fail++; $display("FAIL kv_out_data actual=%h required=69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
      end
      step();
    end
    n_chk++; if (seen - acc_cyc != LAT + 2) begin n_fail++; $display("FAIL kv_latency actual=%0d required=%0d", seen - acc_cyc, LAT + 2); end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk [10];
    int idx = 0;
    for (int i = 0; i < 10; i++) blk[i] = rnd128();
    out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 10);
      in_state = (idx < 10) ? blk[idx] : '0;
      in_key   = (idx < 10) ? ~blk[idx] : '0;
      exp_rdy = (q.size() < DEPTH);
      exp_vld = (q.size() > 0) && (cyc - qt[0] >= LAT + 2);
      n_chk++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, exp_rdy); end
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, exp_vld); end
      if (in_valid && in_ready === 1'b1) idx++;
      step();
    end
    n_chk++; if (idx != DEPTH) begin n_fail++; $display("FAIL bp_accepted actual=%0d required=%0d", idx, DEPTH); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready actual=%b required=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 400 && (idx < 10 || q.size() > 0); c++) begin
      in_valid = (idx < 10);
      in_state = (idx < 10) ? blk[idx] : '0;
      in_key   = (idx < 10) ? ~blk[idx] : '0;
      exp_rdy = (q.size() < DEPTH);
      exp_vld = (q.size() > 0) && (cyc - qt[0] >= LAT + 2);
      n_chk++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_drain_in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, exp_rdy); end
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL bp_drain_out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, exp_vld); end
      if (exp_vld) begin n_chk++; if (out_data !== q[0]) begin n_fail++; $display("FAIL bp_out_data cyc=%0d actual=%h required=%h", cyc, out_data, q[0]); end end
      if (in_valid && in_ready === 1'b1) idx++;
      step();
    end
    in_valid = 1'b0;
    n_chk++; if (idx != 10 || q.size() != 0) begin n_fail++; $display("FAIL bp_complete accepted=%0d outstanding=%0d required=10/0", idx, q.size()); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int p0;
    p0 = pops;
    out_ready = 1'b1;
    for (int c = 0; c < 600 && (idx < 20 || q.size() > 0); c++) begin
      in_valid = (idx < 20);
      in_state = rnd128(); in_key = rnd128();
      exp_rdy = (q.size() < DEPTH);
      exp_vld = (q.size() > 0) && (cyc - qt[0] >= LAT + 2);
      n_chk++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, exp_rdy); end
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL b2b_out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, exp_vld); end
      if (exp_vld) begin n_chk++; if (out_data !== q[0]) begin n_fail++; $display("FAIL b2b_out_data cyc=%0d actual=%h required=%h", cyc, out_data, q[0]); end end
      if (in_valid && in_ready === 1'b1) idx++;
      step();
    end
    in_valid = 1'b0;
    n_chk++; if (pops - p0 != 20) begin n_fail++; $display("FAIL b2b_results actual=%0d required=20", pops - p0); end
  endtask

  task automatic test_reset_midflight();
    int waited;
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = rnd128(); in_key = rnd128();
    step();
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < LAT + 6) begin step(); waited++; end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_first_result actual=%b required=1", out_valid); end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_state = rnd128(); in_key = rnd128();
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready cyc=%0d actual=%b required=1", cyc, in_ready); end
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid_after_rst actual=%b required=0", out_valid); end
    n_chk++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL rm_out_data_after_rst actual=%h required=0", out_data); end
    for (int c = 0; c < 2*LAT + 4; c++) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ghost_result cyc=%0d actual=%b required=0", cyc, out_valid); end
      step();
    end
    in_valid = 1'b1; in_state = rnd128(); in_key = rnd128();
    step();
    in_valid = 1'b0;
    for (int c = 0; c < LAT + 8 && q.size() > 0; c++) begin
      exp_vld = (q.size() > 0) && (cyc - qt[0] >= LAT + 2);
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL rm_post_out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, exp_vld); end
      if (exp_vld) begin n_chk++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rm_post_out_data actual=%h required=%h", out_data, q[0]); end end
      step();
    end
    n_chk++; if (pops != 1) begin n_fail++; $display("FAIL rm_post_results actual=%0d required=1", pops); end
  endtask

  task automatic test_toggle_ready();
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    int           exp_cnt;
    for (int c = 0; c < 400 && (c < 150 || q.size() > 0); c++) begin
      in_valid  = (c < 150);
      out_ready = (c >= 150) || (c % 2 == 0);
      in_state = rnd128(); in_key = rnd128();
      exp_rdy = (q.size() < DEPTH);
      exp_vld = (q.size() > 0) && (cyc - qt[0] >= LAT + 2);
      n_chk++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL tg_in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, exp_rdy); end
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL tg_out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, exp_vld); end
      if (exp_vld) begin n_chk++; if (out_data !== q[0]) begin n_fail++; $display("FAIL tg_out_data cyc=%0d actual=%h required=%h", cyc, out_data, q[0]); end end
      if (prev_stall) begin n_chk++; if (out_data !== prev_data) begin n_fail++; $display("FAIL tg_stall_stable cyc=%0d actual=%h required=%h", cyc, out_data, prev_data); end end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = out_data;
      step();
    end
    in_valid = 1'b0;
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL tg_drain outstanding=%0d required=0", q.size()); end
`ifdef AES_STREAM_BLKCNT_EN
    exp_cnt = pops;
`else
    exp_cnt = 0;
`endif
    n_chk++; if (blk_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL tg_blk_count actual=%0d required=%0d", blk_count, exp_cnt); end
  endtask

  initial begin
    build_sbox();
    @(posedge clk); #1;
    test_reset();
    test_known_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_toggle_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
